// File: rtl/pnc_stmc_addr_packer.sv
// Transmit-side packer for 16-bit STMC address words: pairs local spikes, emits rich-club/parameter words singly.
// Optional macro PNC_PACK_NULL_WORD_EN: a flush serviced in EMPTY emits a 16'h0000 end-of-timestep marker.
module pnc_stmc_addr_packer #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iParamValid,
  input  logic [14:0] iParam,
  output logic        oParamReady,
  input  logic        iSpkValid,
  input  logic        iSpkRich,
  input  logic [13:0] iSpkData,
  output logic        oSpkReady,
  input  logic        iFlush,
  output logic        oAddrValid,
  output logic [15:0] oAddr,
  input  logic        iAddrReady,
  output logic [7:0]  oDropCnt
);

  // Valid/ready: a transfer happens on a clock edge where valid and ready are both high;
  // the output word is held stable while oAddrValid is high and iAddrReady is low.
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_HALF = 2'd1, S_DEFER = 2'd2} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_addr_valid;
  logic [15:0]      r_addr;
  logic [15:0]      r_defer;
  logic [6:0]       r_pend;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flush_req;
  logic [7:0]       r_drop_cnt;

  logic        w_slot_free;
  logic        w_in_ready;
  logic        w_param_acc;
  logic        w_spk_acc;
  logic        w_rich_acc;
  logic        w_null_acc;
  logic        w_local_nz_acc;
  logic        w_any_acc;
  logic        w_flush;
  logic        w_timeout;
  logic        w_hold_done;
  logic [6:0]  w_spk_addr;
  logic [15:0] w_single;

  logic        w_emit;
  logic [15:0] w_word;
  logic        w_load_defer;
  logic [15:0] w_defer_word;
  logic        w_load_pend;
  logic        w_flush_nxt;

  assign w_slot_free    = !r_addr_valid | iAddrReady;
  assign w_in_ready     = w_slot_free & (r_state != S_DEFER);
  assign oParamReady    = w_in_ready;
  assign oSpkReady      = w_in_ready & !iParamValid;
  assign w_param_acc    = iParamValid & w_in_ready;
  assign w_spk_acc      = iSpkValid & w_in_ready & !iParamValid;
  assign w_spk_addr     = iSpkData[6:0];
  assign w_rich_acc     = w_spk_acc & iSpkRich;
  assign w_null_acc     = w_spk_acc & !iSpkRich & (w_spk_addr == 7'd0);
  assign w_local_nz_acc = w_spk_acc & !iSpkRich & (w_spk_addr != 7'd0);
  assign w_any_acc      = w_param_acc | w_spk_acc;
  assign w_flush        = r_flush_req | iFlush;
  assign w_timeout      = (HOLD_MAX != 0) && (r_cnt == CNT_W'(HOLD_MAX - 1));
  // A lone pending address leaves only when nothing was accepted this cycle.
  assign w_hold_done    = (w_flush | w_timeout) & w_slot_free & !w_any_acc;
  assign w_single       = {9'b0, r_pend};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_local_nz_acc & !w_flush) w_state_nxt = S_HALF;
      S_HALF: begin
        if (w_param_acc | w_rich_acc)           w_state_nxt = S_DEFER;
        else if (w_local_nz_acc | w_hold_done)  w_state_nxt = S_EMPTY;
      end
      S_DEFER: if (w_slot_free) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    w_emit       = 1'b0;
    w_word       = 16'h0000;
    w_load_defer = 1'b0;
    w_defer_word = 16'h0000;
    w_load_pend  = 1'b0;
    w_flush_nxt  = w_flush;
    case (r_state)
      S_EMPTY: begin
`ifndef PNC_PACK_NULL_WORD_EN
        w_flush_nxt = 1'b0;
`endif
        if (w_param_acc) begin
          w_emit = 1'b1;
          w_word = {1'b1, iParam};
        end else if (w_rich_acc) begin
          w_emit = 1'b1;
          w_word = {2'b01, iSpkData};
        end else if (w_local_nz_acc & w_flush) begin
          w_emit      = 1'b1;
          w_word      = {9'b0, w_spk_addr};
          w_flush_nxt = 1'b0;
        end else if (w_local_nz_acc) begin
          w_load_pend = 1'b1;
        end
`ifdef PNC_PACK_NULL_WORD_EN
        else if (w_flush & w_slot_free & !w_any_acc) begin
          w_emit      = 1'b1;
          w_word      = 16'h0000;
          w_flush_nxt = 1'b0;
        end
`endif
      end
      S_HALF: begin
        if (w_param_acc | w_rich_acc) begin
          w_emit       = 1'b1;
          w_word       = w_single;
          w_load_defer = 1'b1;
          w_defer_word = w_param_acc ? {1'b1, iParam} : {2'b01, iSpkData};
        end else if (w_local_nz_acc) begin
          w_emit = 1'b1;
          w_word = {2'b00, w_spk_addr, r_pend};
`ifndef PNC_PACK_NULL_WORD_EN
          w_flush_nxt = 1'b0;
`endif
        end else if (w_hold_done) begin
          w_emit      = 1'b1;
          w_word      = w_single;
          w_flush_nxt = 1'b0;
        end
      end
      S_DEFER: begin
        if (w_slot_free) begin
          w_emit = 1'b1;
          w_word = r_defer;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_valid <= 1'b0;
      r_addr       <= 16'h0000;
      r_defer      <= 16'h0000;
      r_pend       <= 7'd0;
      r_cnt        <= '0;
      r_flush_req  <= 1'b0;
      r_drop_cnt   <= 8'd0;
    end else begin
      if (w_emit) begin
        r_addr_valid <= 1'b1;
        r_addr       <= w_word;
      end else if (iAddrReady) begin
        r_addr_valid <= 1'b0;
      end
      if (w_load_defer) r_defer <= w_defer_word;
      if (w_load_pend)  r_pend  <= w_spk_addr;
      if (w_load_pend)
        r_cnt <= '0;
      else if (r_state == S_HALF && r_cnt != CNT_W'(HOLD_MAX - 1))
        r_cnt <= r_cnt + 1'b1;
      r_flush_req <= w_flush_nxt;
      if (w_null_acc && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign oAddrValid = r_addr_valid;
  assign oAddr      = r_addr;
  assign oDropCnt   = r_drop_cnt;

endmodule

// File: tb/tb_pnc_stmc_addr_packer.sv
// Directed testbench for pnc_stmc_addr_packer (default build, HOLD_MAX=16).
module tb_pnc_stmc_addr_packer;

  logic        clk;
  logic        rst;
  logic        iParamValid;
  logic [14:0] iParam;
  logic        oParamReady;
  logic        iSpkValid;
  logic        iSpkRich;
  logic [13:0] iSpkData;
  logic        oSpkReady;
  logic        iFlush;
  logic        oAddrValid;
  logic [15:0] oAddr;
  logic        iAddrReady;
  logic [7:0]  oDropCnt;

  int n_vec = 0;
  int n_err = 0;

  pnc_stmc_addr_packer dut (
    .clk(clk), .rst(rst),
    .iParamValid(iParamValid), .iParam(iParam), .oParamReady(oParamReady),
    .iSpkValid(iSpkValid), .iSpkRich(iSpkRich), .iSpkData(iSpkData), .oSpkReady(oSpkReady),
    .iFlush(iFlush),
    .oAddrValid(oAddrValid), .oAddr(oAddr), .iAddrReady(iAddrReady),
    .oDropCnt(oDropCnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send_spk(input logic rich, input logic [13:0] d);
    iSpkValid = 1'b1;
    iSpkRich  = rich;
    iSpkData  = d;
    tick();
    iSpkValid = 1'b0;
    iSpkRich  = 1'b0;
    iSpkData  = '0;
  endtask

  task automatic pulse_flush;
    iFlush = 1'b1;
    tick();
    iFlush = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_vec++; if (oAddrValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", oAddrValid); end
    n_vec++; if (oAddr !== 16'h0000) begin n_err++; $display("FAIL reset_addr: got %h expected 0000", oAddr); end
    n_vec++; if (oDropCnt !== 8'd0) begin n_err++; $display("FAIL reset_drop: got %0d expected 0", oDropCnt); end
    n_vec++; if (oParamReady !== 1'b1 || oSpkReady !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b%b expected 11", oParamReady, oSpkReady); end
  endtask

  task automatic test_pair;
    send_spk(1'b0, 14'h0005);
    n_vec++; if (oAddrValid !== 1'b0) begin n_err++; $display("FAIL pair_first_hidden: got %b expected 0", oAddrValid); end
    send_spk(1'b0, 14'h0021);
    n_vec++; if (oAddrValid !== 1'b1 || oAddr !== 16'h1085) begin n_err++; $display("FAIL pair_word: got %b/%h expected 1/1085", oAddrValid, oAddr); end
    tick();
    n_vec++; if (oAddrValid !== 1'b0) begin n_err++; $display("FAIL pair_one_cycle: got %b expected 0", oAddrValid); end
  endtask

  task automatic test_timeout;
    logic early;
    early = 1'b0;
    send_spk(1'b0, 14'h000A);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (oAddrValid) early = 1'b1;
    end
    n_vec++; if (early !== 1'b0) begin n_err++; $display("FAIL timeout_early: got %b expected 0", early); end
    tick();
    n_vec++; if (oAddrValid !== 1'b1 || oAddr !== 16'h000A) begin n_err++; $display("FAIL timeout_word: got %b/%h expected 1/000a", oAddrValid, oAddr); end
    tick();
  endtask

  task automatic test_rich_defer;
    send_spk(1'b0, 14'h0003);
    send_spk(1'b1, 14'h1234);
    n_vec++; if (oAddrValid !== 1'b1 || oAddr !== 16'h0003) begin n_err++; $display("FAIL rich_single: got %b/%h expected 1/0003", oAddrValid, oAddr); end
    n_vec++; if (oSpkReady !== 1'b0 || oParamReady !== 1'b0) begin n_err++; $display("FAIL rich_defer_ready: got %b%b expected 00", oParamReady, oSpkReady); end
    tick();
    n_vec++; if (oAddrValid !== 1'b1 || oAddr !== 16'h5234) begin n_err++; $display("FAIL rich_word: got %b/%h expected 1/5234", oAddrValid, oAddr); end
    n_vec++; if (oSpkReady !== 1'b1) begin n_err++; $display("FAIL rich_ready_back: got %b expected 1", oSpkReady); end
    tick();
  endtask

  task automatic test_param_half;
    send_spk(1'b0, 14'h0003);
    iParamValid = 1'b1;
    iParam      = 15'h0123;
    tick();
    iParamValid = 1'b0;
    n_vec++; if (oAddr !== 16'h0003) begin n_err++; $display("FAIL param_half_single: got %h expected 0003", oAddr); end
    tick();
    n_vec++; if (oAddrValid !== 1'b1 || oAddr !== 16'h8123) begin n_err++; $display("FAIL param_half_word: got %b/%h expected 1/8123", oAddrValid, oAddr); end
    tick();
  endtask

  task automatic test_param_priority;
    iParamValid = 1'b1;
    iParam      = 15'h7FFF;
    iSpkValid   = 1'b1;
    iSpkRich    = 1'b0;
    iSpkData    = 14'h0011;
    #1;
    n_vec++; if (oParamReady !== 1'b1 || oSpkReady !== 1'b0) begin n_err++; $display("FAIL prio_ready: got %b%b expected 10", oParamReady, oSpkReady); end
    tick();
    iParamValid = 1'b0;
    n_vec++; if (oAddrValid !== 1'b1 || oAddr !== 16'hFFFF) begin n_err++; $display("FAIL prio_param_word: got %b/%h expected 1/ffff", oAddrValid, oAddr); end
    #1;
    n_vec++; if (oSpkReady !== 1'b1) begin n_err++; $display("FAIL prio_spk_next: got %b expected 1", oSpkReady); end
    tick();
    iSpkValid = 1'b0;
    iSpkData  = '0;
    n_vec++; if (oAddrValid !== 1'b0) begin n_err++; $display("FAIL prio_spk_pending: got %b expected 0", oAddrValid); end
    pulse_flush();
    n_vec++; if (oAddrValid !== 1'b1 || oAddr !== 16'h0011) begin n_err++; $display("FAIL flush_half_word: got %b/%h expected 1/0011", oAddrValid, oAddr); end
    tick();
  endtask

  task automatic test_back_to_back_stall;
    logic bad;
    bad = 1'b0;
    iAddrReady = 1'b0;
    send_spk(1'b0, 14'h0005);
    send_spk(1'b0, 14'h0021);
    iSpkValid = 1'b1;
    iSpkData  = 14'h0009;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (oAddrValid !== 1'b1 || oAddr !== 16'h1085 || oParamReady !== 1'b0 || oSpkReady !== 1'b0) bad = 1'b1;
      tick();
    end
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL stall_hold: got %b/%h rdy %b%b expected 1/1085 rdy 00", oAddrValid, oAddr, oParamReady, oSpkReady); end
    iAddrReady = 1'b1;
    #1;
    n_vec++; if (oAddrValid !== 1'b1 || oAddr !== 16'h1085 || oSpkReady !== 1'b1) begin n_err++; $display("FAIL stall_release: got %b/%h rdy %b expected 1/1085 rdy 1", oAddrValid, oAddr, oSpkReady); end
    tick();
    iSpkValid = 1'b0;
    iSpkData  = '0;
    n_vec++; if (oAddrValid !== 1'b0) begin n_err++; $display("FAIL stall_taken: got %b expected 0", oAddrValid); end
    pulse_flush();
    n_vec++; if (oAddrValid !== 1'b1 || oAddr !== 16'h0009) begin n_err++; $display("FAIL stall_no_loss: got %b/%h expected 1/0009", oAddrValid, oAddr); end
    tick();
  endtask

  task automatic test_drop_sat;
    logic any_word;
    any_word  = 1'b0;
    iSpkValid = 1'b1;
    iSpkRich  = 1'b0;
    for (int k = 0; k < 300; k++) begin
      iSpkData = (k % 2 == 1) ? 14'h3F80 : 14'h0000;
      tick();
      if (oAddrValid) any_word = 1'b1;
      if (k == 99) begin
        n_vec++; if (oDropCnt !== 8'd100) begin n_err++; $display("FAIL drop_count: got %0d expected 100", oDropCnt); end
      end
    end
    iSpkValid = 1'b0;
    iSpkData  = '0;
    n_vec++; if (any_word !== 1'b0) begin n_err++; $display("FAIL drop_no_words: got %b expected 0", any_word); end
    n_vec++; if (oDropCnt !== 8'd255) begin n_err++; $display("FAIL drop_saturate: got %0d expected 255", oDropCnt); end
  endtask

  task automatic test_flush_empty;
    pulse_flush();
`ifdef PNC_PACK_NULL_WORD_EN
    n_vec++; if (oAddrValid !== 1'b1 || oAddr !== 16'h0000) begin n_err++; $display("FAIL flush_empty_marker: got %b/%h expected 1/0000", oAddrValid, oAddr); end
    tick();
`else
    begin
      logic any_word;
      any_word = oAddrValid;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (oAddrValid) any_word = 1'b1;
      end
      n_vec++; if (any_word !== 1'b0) begin n_err++; $display("FAIL flush_empty_silent: got %b expected 0", any_word); end
    end
`endif
  endtask

  task automatic test_flush_spike_half;
    logic any_word;
    any_word = 1'b0;
    send_spk(1'b0, 14'h0005);
    iFlush = 1'b1;
    send_spk(1'b0, 14'h0021);
    iFlush = 1'b0;
    n_vec++; if (oAddrValid !== 1'b1 || oAddr !== 16'h1085) begin n_err++; $display("FAIL flush_pair_word: got %b/%h expected 1/1085", oAddrValid, oAddr); end
    tick();
`ifdef PNC_PACK_NULL_WORD_EN
    n_vec++; if (oAddrValid !== 1'b1 || oAddr !== 16'h0000) begin n_err++; $display("FAIL flush_pair_marker: got %b/%h expected 1/0000", oAddrValid, oAddr); end
    tick();
`endif
    send_spk(1'b0, 14'h000C);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (oAddrValid) any_word = 1'b1;
    end
    n_vec++; if (any_word !== 1'b0) begin n_err++; $display("FAIL flush_req_cleared: got %b expected 0", any_word); end
    pulse_flush();
    n_vec++; if (oAddrValid !== 1'b1 || oAddr !== 16'h000C) begin n_err++; $display("FAIL flush_later_single: got %b/%h expected 1/000c", oAddrValid, oAddr); end
    tick();
  endtask

  task automatic test_flush_spike_empty;
    logic any_word;
    any_word = 1'b0;
    iFlush = 1'b1;
    send_spk(1'b0, 14'h001F);
    iFlush = 1'b0;
    n_vec++; if (oAddrValid !== 1'b1 || oAddr !== 16'h001F) begin n_err++; $display("FAIL flush_spk_empty_word: got %b/%h expected 1/001f", oAddrValid, oAddr); end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (oAddrValid) any_word = 1'b1;
    end
    n_vec++; if (any_word !== 1'b0) begin n_err++; $display("FAIL flush_spk_empty_nothing_left: got %b expected 0", any_word); end
  endtask

  task automatic test_reset_mid;
    logic any_word;
    any_word = 1'b0;
    send_spk(1'b0, 14'h0007);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (oDropCnt !== 8'd0) begin n_err++; $display("FAIL reset_mid_drop: got %0d expected 0", oDropCnt); end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (oAddrValid) any_word = 1'b1;
    end
    n_vec++; if (any_word !== 1'b0) begin n_err++; $display("FAIL reset_mid_discard: got %b expected 0", any_word); end
  endtask

  initial begin
    rst         = 1'b1;
    iParamValid = 1'b0;
    iParam      = '0;
    iSpkValid   = 1'b0;
    iSpkRich    = 1'b0;
    iSpkData    = '0;
    iFlush      = 1'b0;
    iAddrReady  = 1'b1;
    tick();
    test_reset();
    test_pair();
    test_timeout();
    test_rich_defer();
    test_param_half();
    test_param_priority();
    test_back_to_back_stall();
    test_drop_sat();
    test_flush_empty();
    test_flush_spike_half();
    test_flush_spike_empty();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
